// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the regfile writeback
//                arbiter: port widths, the writeback request record and
//                the grant selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 1 << AW;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

    // One-hot decode of a register address into a pending-mask bit.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] addr);
        return NREGS'(1) << addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Writeback bus between the two requesters, the arbiter and
//                the regfile write port.
//                Requester A : a_valid/a_ready/a_addr/a_data (unbuffered)
//                Requester B : b_valid/b_ready/b_addr/b_data (FIFO-buffered)
//                Regfile     : we3/a3/d3 (registered write port)
//                Decode      : pend_mask (pending destinations), b_count
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int FIFO_DEPTH = 2
) ();
    import regfile_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             a_valid;
    logic             a_ready;
    logic [AW-1:0]    a_addr;
    logic [XLEN-1:0]  a_data;
    logic             b_valid;
    logic             b_ready;
    logic [AW-1:0]    b_addr;
    logic [XLEN-1:0]  b_data;
    logic             we3;
    logic [AW-1:0]    a3;
    logic [XLEN-1:0]  d3;
    logic [NREGS-1:0] pend_mask;
    logic [CW-1:0]    b_count;

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we3, a3, d3, pend_mask, b_count
    );

    // Requester / observer side.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we3, a3, d3, pend_mask, b_count
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO of writeback requests. Besides the usual
//                push/pop/full/empty/count/head it exposes every storage
//                slot with a valid bit so the owner can build a hazard mask.
//                Ports: clk, rst, push, push_req, pop, full, empty, count,
//                       head, entries[DEPTH], entry_valid[DEPTH]
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire wb_req_t                push_req,
    input  wire logic                   pop,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output wb_req_t                     head,
    output wb_req_t                     entries [DEPTH],
    output logic [DEPTH-1:0]            entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign entries = mem_q;

    // A slot is live when its distance from the read pointer is below the
    // occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] offset;
        assign offset         = PW'(i) - rd_ptr_q;
        assign entry_valid[i] = ({1'b0, offset} < count_q);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the regfile's single write port between the
//                single-cycle ALU writeback (A, unbuffered) and the
//                multi-cycle LSU/MDU writeback (B, FIFO-buffered). A has
//                priority, but B's head is forced through after losing
//                STARVE_LIMIT consecutive cycles. The write port is
//                registered; pend_mask reports destinations still queued or
//                in flight so decode can stall on hazards.
//                Ports: clk, rst, bus (slave modport of the writeback bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    wb_req_t                push_req;
    wb_req_t                head;
    wb_req_t                gnt_req;
    wb_req_t                entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  entry_valid;
    logic                   full, empty, push, pop, force_head;
    logic [CW-1:0]          count;
    grant_e                 grant;
    logic [NREGS-1:0]       pend_mask;

    logic [3:0]             starve_q, starve_d;
    logic                   we3_q, we3_d;
    logic [AW-1:0]          a3_q, a3_d;
    logic [XLEN-1:0]        d3_q, d3_d;

    assign push_req = '{addr: bus.b_addr, data: bus.b_data};
    assign push     = bus.b_valid && bus.b_ready;
    assign pop      = (grant == GNT_B);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_req    (push_req),
        .pop         (pop),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    assign force_head  = (starve_q == C_LIMIT) && !empty;
    assign bus.a_ready = !rst && !force_head;
    assign bus.b_ready = !rst && !full;

    // Grant: forced head, then A, then head. No bypass from the B input.
    always_comb begin
        grant   = GNT_NONE;
        gnt_req = head;
        if (force_head) begin
            grant = GNT_B;
        end else if (bus.a_valid) begin
            grant   = GNT_A;
            gnt_req = '{addr: bus.a_addr, data: bus.a_data};
        end else if (!empty) begin
            grant = GNT_B;
        end
    end

    // Counts consecutive A wins while B's head waits; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (empty || grant == GNT_B) begin
            starve_d = '0;
        end else if (grant == GNT_A && starve_q != C_LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // x0 writes are consumed but never raise we3; a3/d3 hold when idle.
    always_comb begin
        we3_d = 1'b0;
        a3_d  = a3_q;
        d3_d  = d3_q;
        if (grant != GNT_NONE) begin
            we3_d = (gnt_req.addr != '0);
            a3_d  = gnt_req.addr;
            d3_d  = gnt_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            d3_q     <= '0;
        end else begin
            starve_q <= starve_d;
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            d3_q     <= d3_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend_mask = pend_mask | reg_onehot(entries[i].addr);
            end
        end
        if (we3_q) begin
            pend_mask = pend_mask | reg_onehot(a3_q);
        end
        pend_mask[0] = 1'b0;
    end

    assign bus.we3       = we3_q;
    assign bus.a3        = a3_q;
    assign bus.d3        = d3_q;
    assign bus.pend_mask = pend_mask;
    assign bus.b_count   = count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter. Directed
//                scenarios check against literal expectations; a randomized
//                run checks against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Regfile stand-in capturing on the negedge.
    logic [XLEN-1:0] regs [NREGS];
    always @(negedge clk) begin
        if (bus.we3) regs[bus.a3] <= bus.d3;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    wb_req_t         m_q[$];
    int              m_starve;
    bit              m_we3;
    logic [AW-1:0]   m_a3;
    logic [XLEN-1:0] m_d3;
    bit              m_a_rdy, m_b_rdy;
    bit              obs_a_rdy, obs_b_rdy;

    function automatic logic [NREGS-1:0] m_pend();
        logic [NREGS-1:0] p;
        p = '0;
        foreach (m_q[i]) p[m_q[i].addr] = 1'b1;
        if (m_we3) p[m_a3] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One clock cycle: drive inputs, sample readies before the edge, step the
    // model across the edge, then return 1ns after it.
    task automatic tick(input bit r, input bit av, input logic [AW-1:0] aa,
                        input logic [XLEN-1:0] ad, input bit bv,
                        input logic [AW-1:0] ba, input logic [XLEN-1:0] bd);
        bit      frc, had;
        int      g;
        wb_req_t hd;
        rst         = r;
        bus.a_valid = av;  bus.a_addr = aa;  bus.a_data = ad;
        bus.b_valid = bv;  bus.b_addr = ba;  bus.b_data = bd;
        #3;
        obs_a_rdy = bus.a_ready;
        obs_b_rdy = bus.b_ready;
        frc     = (m_starve == LIMIT) && (m_q.size() > 0);
        m_a_rdy = !r && !frc;
        m_b_rdy = !r && (m_q.size() < DEPTH);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_starve = 0; m_we3 = 0; m_a3 = '0; m_d3 = '0;
        end else begin
            had = (m_q.size() > 0);
            g   = 0;
            if (frc)      g = 2;
            else if (av)  g = 1;
            else if (had) g = 2;
            if (g == 1) begin
                m_we3 = (aa != 0); m_a3 = aa; m_d3 = ad;
            end else if (g == 2) begin
                hd = m_q.pop_front();
                m_we3 = (hd.addr != 0); m_a3 = hd.addr; m_d3 = hd.data;
            end else begin
                m_we3 = 0;
            end
            if (bv && m_b_rdy) m_q.push_back('{addr: ba, data: bd});
            if (!had || g == 2)               m_starve = 0;
            else if (g == 1 && m_starve < LIMIT) m_starve++;
        end
        #1;
    endtask

    task automatic do_reset();
        tick(1, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic idle();
        tick(0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_reset();
        tick(1, 1, 5'd3, 32'h55, 1, 5'd4, 32'h66);
        n_cmp++; if (obs_a_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %0b want 0", obs_a_rdy); end
        n_cmp++; if (obs_b_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %0b want 0", obs_b_rdy); end
        n_cmp++; if (bus.we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %0b want 0", bus.we3); end
        n_cmp++; if (bus.a3 !== 5'd0) begin n_fail++; $display("FAIL reset_a3: got %0d want 0", bus.a3); end
        n_cmp++; if (bus.d3 !== 32'd0) begin n_fail++; $display("FAIL reset_d3: got %h want 0", bus.d3); end
        n_cmp++; if (bus.pend_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pend: got %h want 0", bus.pend_mask); end
        n_cmp++; if (bus.b_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.b_count); end
    endtask

    task automatic test_a_alone();
        do_reset();
        tick(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        n_cmp++; if (obs_a_rdy !== 1'b1) begin n_fail++; $display("FAIL a_ready: got %0b want 1", obs_a_rdy); end
        n_cmp++; if (bus.we3 !== 1'b1) begin n_fail++; $display("FAIL a_we3: got %0b want 1", bus.we3); end
        n_cmp++; if (bus.a3 !== 5'd5) begin n_fail++; $display("FAIL a_a3: got %0d want 5", bus.a3); end
        n_cmp++; if (bus.d3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_d3: got %h want deadbeef", bus.d3); end
        n_cmp++; if (bus.pend_mask !== 32'h20) begin n_fail++; $display("FAIL a_pend: got %h want 00000020", bus.pend_mask); end
        idle();
        n_cmp++; if (regs[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_regfile: got %h want deadbeef", regs[5]); end
        n_cmp++; if (bus.we3 !== 1'b0) begin n_fail++; $display("FAIL a_we3_drop: got %0b want 0", bus.we3); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_fail++; $display("FAIL a_pend_clear: got %h want 0", bus.pend_mask); end
    endtask

    task automatic test_x0_drop();
        do_reset();
        tick(0, 1, 5'd0, 32'h1234, 0, '0, '0);
        n_cmp++; if (obs_a_rdy !== 1'b1) begin n_fail++; $display("FAIL x0_a_ready: got %0b want 1", obs_a_rdy); end
        n_cmp++; if (bus.we3 !== 1'b0) begin n_fail++; $display("FAIL x0_we3: got %0b want 0", bus.we3); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_fail++; $display("FAIL x0_pend: got %h want 0", bus.pend_mask); end
    endtask

    task automatic test_b_alone();
        do_reset();
        tick(0, 0, '0, '0, 1, 5'd7, 32'h11);
        n_cmp++; if (obs_b_rdy !== 1'b1) begin n_fail++; $display("FAIL b_ready: got %0b want 1", obs_b_rdy); end
        n_cmp++; if (bus.b_count !== 2'd1) begin n_fail++; $display("FAIL b_count1: got %0d want 1", bus.b_count); end
        n_cmp++; if (bus.pend_mask !== 32'h80) begin n_fail++; $display("FAIL b_pend: got %h want 00000080", bus.pend_mask); end
        n_cmp++; if (bus.we3 !== 1'b0) begin n_fail++; $display("FAIL b_no_bypass: got %0b want 0", bus.we3); end
        idle();
        n_cmp++; if (bus.we3 !== 1'b1) begin n_fail++; $display("FAIL b_we3: got %0b want 1", bus.we3); end
        n_cmp++; if (bus.a3 !== 5'd7) begin n_fail++; $display("FAIL b_a3: got %0d want 7", bus.a3); end
        n_cmp++; if (bus.d3 !== 32'h11) begin n_fail++; $display("FAIL b_d3: got %h want 11", bus.d3); end
        n_cmp++; if (bus.b_count !== 2'd0) begin n_fail++; $display("FAIL b_count0: got %0d want 0", bus.b_count); end
    endtask

    task automatic test_starvation();
        int k;
        logic [AW-1:0] exp_a3 [7];
        exp_a3 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd6};
        do_reset();
        k = 1;
        for (int i = 0; i < 7; i++) begin
            tick(0, 1, AW'(k), XLEN'(k * 256), (i == 0), 5'd9, 32'h99);
            n_cmp++; if (obs_a_rdy !== (i != 5)) begin n_fail++; $display("FAIL starve_a_ready[%0d]: got %0b want %0b", i, obs_a_rdy, (i != 5)); end
            n_cmp++; if (bus.we3 !== 1'b1 || bus.a3 !== exp_a3[i]) begin n_fail++; $display("FAIL starve_a3[%0d]: got we3=%0b a3=%0d want we3=1 a3=%0d", i, bus.we3, bus.a3, exp_a3[i]); end
            if (obs_a_rdy) k++;
        end
    endtask

    task automatic test_full_fifo();
        logic [AW-1:0] seen[$];
        int k;
        bit saw12;
        do_reset();
        k = 1; saw12 = 0;
        for (int i = 0; i < 24; i++) begin
            tick(0, 1, AW'(k % 8 + 1), XLEN'(k), (i < 3), AW'(10 + i), XLEN'(32'hA0 + i));
            if (obs_a_rdy) k++;
            if (i == 1) begin
                n_cmp++; if (bus.b_count !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d want 2", bus.b_count); end
            end
            if (i == 2) begin
                n_cmp++; if (obs_b_rdy !== 1'b0) begin n_fail++; $display("FAIL full_b_ready: got %0b want 0", obs_b_rdy); end
            end
            if (bus.we3 && bus.a3 >= 5'd10) begin
                if (bus.a3 == 5'd12) saw12 = 1;
                else seen.push_back(bus.a3);
            end
        end
        n_cmp++; if (seen.size() != 2) begin n_fail++; $display("FAIL full_drain_count: got %0d want 2", seen.size()); end
        else begin
            n_cmp++; if (seen[0] !== 5'd10 || seen[1] !== 5'd11) begin n_fail++; $display("FAIL full_order: got %0d,%0d want 10,11", seen[0], seen[1]); end
        end
        n_cmp++; if (saw12) begin n_fail++; $display("FAIL full_overflow: got write to 12 want none"); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        tick(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20);
        tick(0, 1, 5'd2, 32'h2, 1, 5'd21, 32'h21);
        n_cmp++; if (bus.b_count !== 2'd2) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 2", bus.b_count); end
        tick(1, 1, 5'd3, 32'h3, 0, '0, '0);
        n_cmp++; if (bus.b_count !== 2'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", bus.b_count); end
        n_cmp++; if (bus.pend_mask !== 32'h0) begin n_fail++; $display("FAIL mid_pend: got %h want 0", bus.pend_mask); end
        n_cmp++; if (bus.we3 !== 1'b0) begin n_fail++; $display("FAIL mid_we3: got %0b want 0", bus.we3); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (bus.we3 && (bus.a3 == 5'd20 || bus.a3 == 5'd21)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL mid_dropped: got %0d stale writes want 0", bad); end
    endtask

    task automatic test_random();
        bit r, av, bv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            av = ($urandom_range(0, 99) < 55);
            bv = ($urandom_range(0, 99) < 45);
            tick(r, av, AW'($urandom_range(0, 7)), $urandom(),
                 bv, AW'($urandom_range(0, 7)), $urandom());
            n_cmp++; if (obs_a_rdy !== m_a_rdy) begin n_fail++; $display("FAIL rnd_a_ready[%0d]: got %0b want %0b", i, obs_a_rdy, m_a_rdy); end
            n_cmp++; if (obs_b_rdy !== m_b_rdy) begin n_fail++; $display("FAIL rnd_b_ready[%0d]: got %0b want %0b", i, obs_b_rdy, m_b_rdy); end
            n_cmp++; if (bus.we3 !== m_we3) begin n_fail++; $display("FAIL rnd_we3[%0d]: got %0b want %0b", i, bus.we3, m_we3); end
            n_cmp++; if (bus.a3 !== m_a3) begin n_fail++; $display("FAIL rnd_a3[%0d]: got %0d want %0d", i, bus.a3, m_a3); end
            n_cmp++; if (bus.d3 !== m_d3) begin n_fail++; $display("FAIL rnd_d3[%0d]: got %h want %h", i, bus.d3, m_d3); end
            n_cmp++; if (bus.pend_mask !== m_pend()) begin n_fail++; $display("FAIL rnd_pend[%0d]: got %h want %h", i, bus.pend_mask, m_pend()); end
            n_cmp++; if (bus.b_count !== 2'(m_q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.b_count, m_q.size()); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.a_valid = 1'b0;  bus.a_addr = '0;  bus.a_data = '0;
        bus.b_valid = 1'b0;  bus.b_addr = '0;  bus.b_data = '0;
        m_starve = 0; m_we3 = 0; m_a3 = '0; m_d3 = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_a_alone();
        test_x0_drop();
        test_b_alone();
        test_starvation();
        test_full_fifo();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
